// File: rtl/aes_bridge_pkg.sv
// Shared types and constants for the AES FIFO host bridge.
package aes_bridge_pkg;

  localparam int SEQ_WIDTH = 8;

  // Field positions inside ififo_din for the default 8-bit key/data build
  localparam int KEY_MSB  = 15;
  localparam int KEY_LSB  = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  typedef enum logic [1:0] {
    R_IDLE,
    R_POP,
    R_CAPT,
    R_HOLD
  } rd_state_e;

endpackage

// File: rtl/aes_bridge_tracker.sv
// Outstanding-request tracker, unexpected-result flag and optional stall
// timeout (enabled by AES_BRIDGE_TIMEOUT_EN).
module aes_bridge_tracker
  import aes_bridge_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 16,
  parameter int TIMEOUT_CYCLES  = 4096,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          req_hs,
  input  logic          rsp_hs,
  input  logic          capt,
  input  logic          stall,
  output logic [CW-1:0] outstanding,
  output logic          err_unexpected,
  output logic          err_timeout
);

  logic flush;

`ifdef AES_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] stall_cnt;

  assign flush = stall && (outstanding != '0) && !rsp_hs &&
                 (stall_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (rst) begin
      stall_cnt   <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (flush)
        err_timeout <= 1'b1;
      if (rsp_hs || outstanding == '0 || flush)
        stall_cnt <= '0;
      else if (stall)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign flush       = 1'b0;
  assign err_timeout = 1'b0;
  assign unused_cfg  = ^{stall, TIMEOUT_CYCLES};
`endif

  always_ff @(posedge clock) begin
    if (rst)
      outstanding <= '0;
    else if (flush)
      outstanding <= '0;
    else if (req_hs && !rsp_hs)
      outstanding <= outstanding + 1'b1;
    else if (!req_hs && rsp_hs && outstanding != '0)
      outstanding <= outstanding - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (rst)
      err_unexpected <= 1'b0;
    else if (capt && outstanding == '0)
      err_unexpected <= 1'b1;
  end

endmodule

// File: rtl/aes_fifo_host_bridge.sv
// Host bridge: packs key/data requests into the AES input FIFO and returns
// ciphertext with a sequence tag. Optional stall timeout: AES_BRIDGE_TIMEOUT_EN.
module aes_fifo_host_bridge
  import aes_bridge_pkg::*;
#(
  parameter int KEY_WIDTH       = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int MAX_OUTSTANDING = 16,
  parameter int TIMEOUT_CYCLES  = 4096,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [KEY_WIDTH-1:0]          req_key,
  input  logic [DATA_WIDTH-1:0]         req_data,
  input  logic                          ififo_full,
  output logic                          ififo_wr,
  output logic [KEY_WIDTH+DATA_WIDTH-1:0] ififo_din,
  input  logic                          ofifo_empty,
  output logic                          ofifo_rd,
  input  logic [DATA_WIDTH-1:0]         ofifo_dout,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [SEQ_WIDTH-1:0]          rsp_seq,
  output logic [CW-1:0]                 outstanding,
  output logic                          err_unexpected,
  output logic                          err_timeout
);

  rd_state_e state, state_nx;
  logic      req_hs, rsp_hs, capt, stall;

  assign req_ready = !rst && !ififo_full &&
                     (outstanding < CW'(MAX_OUTSTANDING));
  assign ififo_wr  = req_valid && req_ready;
  assign ififo_din = {req_key, req_data};

  assign req_hs = ififo_wr;
  assign rsp_hs = rsp_valid && rsp_ready;
  assign capt   = (state == R_CAPT);
  assign stall  = (state == R_IDLE) && ofifo_empty;

  always_ff @(posedge clock) begin
    if (rst)
      state <= R_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ofifo_rd = 1'b0;
    unique case (state)
      R_IDLE: if (!ofifo_empty) state_nx = R_POP;
      R_POP: begin
        ofifo_rd = !rst;
        state_nx = R_CAPT;
      end
      R_CAPT: state_nx = R_HOLD;
      R_HOLD: if (rsp_ready) state_nx = R_IDLE;
      default: state_nx = R_IDLE;
    endcase
  end

  // Single response buffer; read data is valid in R_CAPT (1-cycle FIFO latency)
  always_ff @(posedge clock) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_seq   <= '0;
    end else if (capt) begin
      rsp_valid <= 1'b1;
      rsp_data  <= ofifo_dout;
    end else if (rsp_hs) begin
      rsp_valid <= 1'b0;
      rsp_seq   <= rsp_seq + 1'b1;
    end
  end

  aes_bridge_tracker #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
  ) u_tracker (
    .clock          (clock),
    .rst            (rst),
    .req_hs         (req_hs),
    .rsp_hs         (rsp_hs),
    .capt           (capt),
    .stall          (stall),
    .outstanding    (outstanding),
    .err_unexpected (err_unexpected),
    .err_timeout    (err_timeout)
  );

endmodule

// File: tb/tb_aes_fifo_host_bridge.sv
// Directed self-checking bench for aes_fifo_host_bridge.
module tb_aes_fifo_host_bridge;
  import aes_bridge_pkg::*;

  logic        clock = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [7:0]  req_key, req_data;
  logic        ififo_full, ififo_wr;
  logic [15:0] ififo_din;
  logic        ofifo_empty, ofifo_rd;
  logic [7:0]  ofifo_dout;
  logic        rsp_valid, rsp_ready;
  logic [7:0]  rsp_data, rsp_seq;
  logic [4:0]  outstanding;
  logic        err_unexpected, err_timeout;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_seq;

  always #5 clock = ~clock;

  aes_fifo_host_bridge #(
    .KEY_WIDTH       (8),
    .DATA_WIDTH      (8),
    .MAX_OUTSTANDING (16),
    .TIMEOUT_CYCLES  (64)
  ) dut (
    .clock          (clock),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_key        (req_key),
    .req_data       (req_data),
    .ififo_full     (ififo_full),
    .ififo_wr       (ififo_wr),
    .ififo_din      (ififo_din),
    .ofifo_empty    (ofifo_empty),
    .ofifo_rd       (ofifo_rd),
    .ofifo_dout     (ofifo_dout),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_seq        (rsp_seq),
    .outstanding    (outstanding),
    .err_unexpected (err_unexpected),
    .err_timeout    (err_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] k, input logic [7:0] d);
    req_key   = k;
    req_data  = d;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  // empty low for one cycle; returns with the response held (N+3)
  task automatic pop(input logic [7:0] d);
    ofifo_dout  = d;
    ofifo_empty = 1'b0;
    step();
    ofifo_empty = 1'b1;
    step();
    step();
  endtask

  task automatic rsp_hs();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 0; req_key = 0; req_data = 0;
    ififo_full = 0; ofifo_empty = 1; ofifo_dout = 0; rsp_ready = 0;

    // reset with inputs toggling
    for (int i = 0; i < 4; i++) begin
      req_valid   = 1'($urandom);
      req_key     = 8'($urandom);
      req_data    = 8'($urandom);
      ififo_full  = 1'($urandom);
      ofifo_empty = 1'($urandom);
      ofifo_dout  = 8'($urandom);
      rsp_ready   = 1'($urandom);
      step();
      check("rst_outs", {req_ready, ififo_wr, ofifo_rd, rsp_valid, rsp_data,
            rsp_seq, outstanding, err_unexpected, err_timeout}, 0);
    end
    rst = 0; req_valid = 0; ififo_full = 0; ofifo_empty = 1; rsp_ready = 0;
    #1;
    check("post_rst_outs", {ififo_wr, ofifo_rd, rsp_valid, rsp_data, rsp_seq,
          outstanding, err_unexpected, err_timeout}, 0);
    step();
    check("post_rst_rdy", req_ready, 1);

    // full FIFO blocks the handshake
    ififo_full = 1; req_valid = 1; req_key = 8'h77; req_data = 8'h66;
    #1;
    check("full_rdy", req_ready, 0);
    check("full_wr", ififo_wr, 0);
    step();
    check("full_outst", outstanding, 0);
    req_valid = 0; ififo_full = 0;

    // single transaction
    req_key = 8'h2B; req_data = 8'h32; req_valid = 1;
    #1;
    check("wr_strobe", ififo_wr, 1);
    check("wr_din", ififo_din, 16'h2B32);
    check("wr_key", ififo_din[KEY_MSB:KEY_LSB], 8'h2B);
    check("wr_data", ififo_din[DATA_MSB:DATA_LSB], 8'h32);
    step();
    req_valid = 0;
    check("outst_1", outstanding, 1);
    ofifo_dout = 8'h39; ofifo_empty = 0;
    step();
    check("rd_n1", ofifo_rd, 1);
    ofifo_empty = 1;
    step();
    check("rd_n2", {ofifo_rd, rsp_valid}, 0);
    step();
    check("rsp_n3", {rsp_valid, rsp_data, rsp_seq}, {1'b1, 8'h39, 8'h00});
    rsp_hs();
    check("after_hs", {rsp_valid, outstanding, err_unexpected}, 0);

    // back-pressure with results still waiting in the FIFO
    send(8'h01, 8'h02);
    ofifo_dout = 8'hA5; ofifo_empty = 0;
    step(); step(); step();
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", {rsp_valid, rsp_data, rsp_seq, ofifo_rd},
            {1'b1, 8'hA5, 8'h01, 1'b0});
      step();
    end
    ofifo_empty = 1;
    rsp_hs();
    check("bp_done", {rsp_valid, outstanding}, 0);

    // credit limit
    req_valid = 1; req_data = 8'h00;
    for (int i = 0; i < 16; i++) begin
      req_key = 8'(i);
      #0;
      check("credit_rdy", req_ready, 1);
      step();
    end
    check("credit_17", {req_ready, ififo_wr}, 0);
    check("credit_cnt", outstanding, 16);
    pop(8'h11);
    check("credit_rsp", {rsp_valid, rsp_data, rsp_seq}, {1'b1, 8'h11, 8'h02});
    rsp_ready = 1;
    #0;
    check("credit_same", req_ready, 0);
    step();
    rsp_ready = 0;
    check("credit_next", req_ready, 1);
    req_valid = 0;
    check("credit_cnt15", outstanding, 15);

    // sequence wrap: drain 15, then request/response pairs
    exp_seq = 8'h03;
    for (int i = 0; i < 256; i++) begin
      if (i >= 15) send(8'(i), 8'(i));
      pop(8'(i));
      check("wrap_seq", {rsp_valid, rsp_seq}, {1'b1, exp_seq});
      rsp_hs();
      exp_seq = exp_seq + 8'h01;
    end
    check("wrap_end", {outstanding, err_unexpected, rsp_seq}, {5'd0, 1'b0, 8'h03});

    // unexpected result
    pop(8'h5C);
    check("unexp", {err_unexpected, rsp_valid, rsp_data}, {1'b1, 1'b1, 8'h5C});
    rsp_hs();
    check("unexp_after", {outstanding, err_unexpected}, {5'd0, 1'b1});

    // stall timeout
    send(8'hA0, 8'h00);
    send(8'hA1, 8'h01);
    send(8'hA2, 8'h02);
    for (int i = 0; i < 50; i++) step();
    check("to_early", {err_timeout, outstanding}, {1'b0, 5'd3});
    for (int i = 0; i < 20; i++) step();
`ifdef AES_BRIDGE_TIMEOUT_EN
    check("to_fired", {err_timeout, outstanding}, {1'b1, 5'd0});
`else
    check("to_off", {err_timeout, outstanding}, {1'b0, 5'd3});
`endif

    // reset in the middle of a pop
    ofifo_empty = 0;
    step();
    check("mid_pop", ofifo_rd, 1);
    rst = 1;
    step();
    check("mid_rst", {ofifo_rd, rsp_valid, outstanding, err_unexpected,
          err_timeout, rsp_seq}, 0);
    rst = 0; ofifo_empty = 1;
    step();
    check("mid_after", {ofifo_rd, rsp_valid, req_ready}, {1'b0, 1'b0, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
